icache_ctrl: RTL

//  Direct-mapped, read-only instruction cache between the fetch stage and main memory.

---
 rtl/icache_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with flop-based tag/data storage.
// Misses stall fetch, refill one line in ascending word beats, then return the word.
module icache_ctrl #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_re,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_dout,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned SEL_W = IDX_W + OFF_W;
  localparam int unsigned TAG_W = 30 - SEL_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [29:0]       waddr_q, waddr_d;
  logic [OFF_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic [TAG_W-1:0]  tag_arr_q [LINES];
  logic [31:0]       data_q    [LINES*LINE_WORDS];

  logic [IDX_W-1:0]  idx_c;
  logic [OFF_W-1:0]  off_c;
  logic [TAG_W-1:0]  tag_c;
  logic              hit_c;
  logic [31:0]       rd_word_c;
  logic              data_we_c;
  logic              tag_we_c;
  logic              unused_addr_lsb;

  // Byte-offset bits never select anything; the word address is all that is kept.
  assign unused_addr_lsb = ^icache_addr[1:0];

  assign off_c     = waddr_q[OFF_W-1:0];
  assign idx_c     = waddr_q[SEL_W-1:OFF_W];
  assign tag_c     = waddr_q[29:SEL_W];
  assign hit_c     = valid_q[idx_c] && (tag_arr_q[idx_c] == tag_c);
  assign rd_word_c = data_q[waddr_q[SEL_W-1:0]];

  assign mem_req_addr = {tag_c, idx_c, (OFF_W+2)'(0)};
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

  // Fetch-facing outputs decode straight from state so a hit costs no extra cycle.
  always_comb begin
    stall         = 1'b0;
    icache_dout   = '0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_q) begin
          if (hit_c) icache_dout = rd_word_c;
          else       stall       = 1'b1;
        end
      end
      MISS_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      REFILL:  stall       = 1'b1;
      DONE:    icache_dout = rd_word_c;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    waddr_d      = waddr_q;
    beat_cnt_d   = beat_cnt_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    data_we_c    = 1'b0;
    tag_we_c     = 1'b0;

    if (!stall) begin
      req_d   = icache_re;
      waddr_d = icache_addr[31:2];
    end

    case (state_q)
      IDLE: begin
        if (req_q) begin
          if (hit_c) begin
            hit_count_d = hit_count_q + 32'd1;
          end else begin
            miss_count_d = miss_count_q + 32'd1;
            state_d      = MISS_REQ;
          end
        end
        if (flush) valid_d = '0;
      end
      MISS_REQ: begin
        if (mem_req_ready) begin
          state_d    = REFILL;
          beat_cnt_d = '0;
        end
      end
      REFILL: begin
        if (mem_resp_valid) begin
          data_we_c  = 1'b1;
          beat_cnt_d = beat_cnt_q + OFF_W'(1);
          if (beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_we_c = 1'b1;
            if (!(flush_pend_q || flush)) valid_d[idx_c] = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        flush_pend_d = 1'b0;
        // A flush seen during the miss takes effect as the FSM returns to IDLE.
        if (flush_pend_q || flush) valid_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (flush && (state_q == MISS_REQ || state_q == REFILL)) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      waddr_q      <= '0;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      waddr_q      <= waddr_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (data_we_c) data_q[{idx_c, beat_cnt_q}] <= mem_resp_data;
    if (tag_we_c)  tag_arr_q[idx_c]            <= tag_c;
  end

endmodule
